// File: rtl/count_seq_checker_if.sv
// ---------------------------------------------------------------------------
// count_seq_checker_if
// Groups the sample stream and status outputs of count_seq_checker.
//   valid       : count_in is sampled this cycle when high
//   count_in    : observed value of a free-running modulo-16 up counter
//   clear_err   : synchronous clear of err_count
//   locked      : checker is in LOCKED
//   err         : one-cycle pulse per out-of-sequence sample while LOCKED
//   expected    : next value the checker predicts
//   wrap_pulse  : one-cycle pulse on an in-sequence 15->0 wrap while LOCKED
//   err_count   : saturating count of err pulses
//   wrap_count  : modulo-256 count of wrap_pulse events
// master drives the sample stream; slave is the checker.
// ---------------------------------------------------------------------------
interface count_seq_checker_if;
   logic       valid;
   logic [3:0] count_in;
   logic       clear_err;
   logic       locked;
   logic       err;
   logic [3:0] expected;
   logic       wrap_pulse;
   logic [7:0] err_count;
   logic [7:0] wrap_count;

   modport master (
      output valid, count_in, clear_err,
      input  locked, err, expected, wrap_pulse, err_count, wrap_count
   );

   modport slave (
      input  valid, count_in, clear_err,
      output locked, err, expected, wrap_pulse, err_count, wrap_count
   );
endinterface

// File: rtl/count_seq_checker.sv
// ---------------------------------------------------------------------------
// count_seq_checker
// Tracks a modulo-16 up counter observed on count_in, locks after
// LOCK_THRESH consecutive in-sequence samples and drops lock after
// UNLOCK_THRESH consecutive out-of-sequence samples.
// Ports:
//   clk    : sole clock, rising edge
//   reset  : asynchronous, active-low reset
//   bus    : count_seq_checker_if.slave (sample stream in, status out)
// All outputs are registered and reflect a sample one clk later.
// Optional macro SEQ_CHECK_STATS_EN: when defined, err_count/wrap_count
// statistics and clear_err are implemented; otherwise the counters read 0
// and clear_err is ignored.
// ---------------------------------------------------------------------------
module count_seq_checker #(
   parameter int unsigned LOCK_THRESH   = 4,
   parameter int unsigned UNLOCK_THRESH = 2
) (
   input logic               clk,
   input logic               reset,
   count_seq_checker_if.slave bus
);

   typedef enum logic [1:0] {HUNT, SYNC, LOCKED} state_e;

   localparam logic [3:0] LOCK_N   = 4'(LOCK_THRESH);
   localparam logic [3:0] UNLOCK_N = 4'(UNLOCK_THRESH);

   state_e     state_q, state_d;
   logic [3:0] run_q, run_d;
   logic [3:0] miss_q, miss_d;
   logic [3:0] exp_q, exp_d;
   logic       locked_q;
   logic       err_q, err_d;
   logic       wrap_q, wrap_d;
   logic       match;

   always_comb begin
      state_d = state_q;
      run_d   = run_q;
      miss_d  = miss_q;
      exp_d   = exp_q;
      err_d   = 1'b0;
      wrap_d  = 1'b0;
      match   = bus.valid && (bus.count_in == exp_q);

      if (bus.valid) begin
         unique case (state_q)
            HUNT: begin
               exp_d   = bus.count_in + 4'd1;
               run_d   = 4'd1;
               state_d = SYNC;
            end
            SYNC: begin
               if (match) begin
                  exp_d = exp_q + 4'd1;
                  run_d = run_q + 4'd1;
                  if (run_q + 4'd1 == LOCK_N) begin
                     state_d = LOCKED;
                     miss_d  = 4'd0;
                  end
               end else begin
                  exp_d = bus.count_in + 4'd1;
                  run_d = 4'd1;
               end
            end
            LOCKED: begin
               if (match) begin
                  exp_d  = exp_q + 4'd1;
                  miss_d = 4'd0;
                  wrap_d = (bus.count_in == 4'd0);
               end else begin
                  // The sample that drops lock still reports its error.
                  err_d  = 1'b1;
                  exp_d  = bus.count_in + 4'd1;
                  miss_d = miss_q + 4'd1;
                  if (miss_q + 4'd1 == UNLOCK_N) state_d = HUNT;
               end
            end
            default: state_d = HUNT;
         endcase
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q  <= HUNT;
         run_q    <= '0;
         miss_q   <= '0;
         exp_q    <= '0;
         locked_q <= 1'b0;
         err_q    <= 1'b0;
         wrap_q   <= 1'b0;
      end else begin
         state_q  <= state_d;
         run_q    <= run_d;
         miss_q   <= miss_d;
         exp_q    <= exp_d;
         locked_q <= (state_d == LOCKED);
         err_q    <= err_d;
         wrap_q   <= wrap_d;
      end
   end

   assign bus.locked     = locked_q;
   assign bus.err        = err_q;
   assign bus.expected   = exp_q;
   assign bus.wrap_pulse = wrap_q;

`ifdef SEQ_CHECK_STATS_EN
   logic [7:0] err_cnt_q, err_cnt_d;
   logic [7:0] wrap_cnt_q, wrap_cnt_d;

   always_comb begin
      err_cnt_d  = err_cnt_q;
      wrap_cnt_d = wrap_cnt_q;
      // A clear coinciding with an error keeps that error counted.
      if (bus.clear_err)                     err_cnt_d = {7'd0, err_d};
      else if (err_d && (err_cnt_q != '1))   err_cnt_d = err_cnt_q + 8'd1;
      if (wrap_d)                            wrap_cnt_d = wrap_cnt_q + 8'd1;
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         err_cnt_q  <= '0;
         wrap_cnt_q <= '0;
      end else begin
         err_cnt_q  <= err_cnt_d;
         wrap_cnt_q <= wrap_cnt_d;
      end
   end

   assign bus.err_count  = err_cnt_q;
   assign bus.wrap_count = wrap_cnt_q;
`else
   logic unused_clear_err;
   assign unused_clear_err = bus.clear_err;
   assign bus.err_count    = '0;
   assign bus.wrap_count   = '0;
`endif

endmodule

// File: tb/tb_count_seq_checker.sv
// ---------------------------------------------------------------------------
// tb_count_seq_checker
// Self-checking bench for count_seq_checker: a reference model predicts the
// registered outputs for each driven sample and queues them; they are
// compared one clock later. A hand-derived vector table also pins the core
// lock/err/wrap behaviour independently of the model.
// ---------------------------------------------------------------------------
module tb_count_seq_checker;

   localparam int LOCK   = 4;
   localparam int UNLOCK = 2;

`ifdef SEQ_CHECK_STATS_EN
   localparam bit STATS = 1'b1;
`else
   localparam bit STATS = 1'b0;
`endif

   logic clk;
   logic reset;

   count_seq_checker_if bus ();

   count_seq_checker #(
      .LOCK_THRESH   (LOCK),
      .UNLOCK_THRESH (UNLOCK)
   ) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      bit       locked;
      bit       err;
      bit [3:0] expected;
      bit       wrap;
      bit [7:0] errc;
      bit [7:0] wrapc;
   } exp_t;

   typedef struct {
      bit       v;
      bit [3:0] c;
      bit       clr;
      bit       lk;
      bit       er;
      bit [3:0] ex;
      bit       wr;
   } vec_t;

   exp_t sb[$];
   int   n_cmp = 0;
   int   n_bad = 0;

   // reference model state
   int       mstate;   // 0 hunt, 1 sync, 2 locked
   int       mrun, mmiss;
   bit [3:0] mexp;
   bit [7:0] merrc, mwrapc;

   task automatic model_reset();
      mstate = 0; mrun = 0; mmiss = 0; mexp = 4'd0; merrc = 8'd0; mwrapc = 8'd0;
   endtask

   task automatic model_step(input bit v, input bit [3:0] c, input bit clr, output exp_t e);
      bit e_err, e_wrap;
      e_err = 1'b0;
      e_wrap = 1'b0;
      if (v) begin
         if (mstate == 0) begin
            mexp = c + 4'd1; mrun = 1; mstate = 1;
         end else if (mstate == 1) begin
            if (c == mexp) begin
               mexp = mexp + 4'd1; mrun = mrun + 1;
               if (mrun == LOCK) begin mstate = 2; mmiss = 0; end
            end else begin
               mexp = c + 4'd1; mrun = 1;
            end
         end else begin
            if (c == mexp) begin
               e_wrap = (c == 4'd0); mexp = mexp + 4'd1; mmiss = 0;
            end else begin
               e_err = 1'b1; mexp = c + 4'd1; mmiss = mmiss + 1;
               if (mmiss == UNLOCK) mstate = 0;
            end
         end
      end
      if (STATS) begin
         if (clr) merrc = e_err ? 8'd1 : 8'd0;
         else if (e_err && merrc != 8'd255) merrc = merrc + 8'd1;
         if (e_wrap) mwrapc = mwrapc + 8'd1;
      end
      e.locked = (mstate == 2); e.err = e_err; e.expected = mexp; e.wrap = e_wrap;
      e.errc = merrc; e.wrapc = mwrapc;
   endtask

   task automatic chk(input string nm, input int act, input int req);
      n_cmp++;
      if (act != req) begin
         n_bad++;
         $display("FAIL %s: got %0d, required %0d (t=%0t)", nm, act, req, $time);
      end
   endtask

   task automatic step(input bit v, input bit [3:0] c, input bit clr);
      exp_t e;
      @(negedge clk);
      bus.valid = v; bus.count_in = c; bus.clear_err = clr;
      model_step(v, c, clr, e);
      sb.push_back(e);
      @(posedge clk);
      #1;
      if (sb.size() == 0) begin
         n_cmp++; n_bad++;
         $display("FAIL sb_underflow: got empty queue, required one entry");
      end else begin
         e = sb.pop_front();
         chk("locked", int'(bus.locked), int'(e.locked));
         chk("err", int'(bus.err), int'(e.err));
         chk("expected", int'(bus.expected), int'(e.expected));
         chk("wrap_pulse", int'(bus.wrap_pulse), int'(e.wrap));
         chk("err_count", int'(bus.err_count), int'(e.errc));
         chk("wrap_count", int'(bus.wrap_count), int'(e.wrapc));
      end
   endtask

   task automatic chk_all_zero(input string nm);
      chk({nm, "_locked"}, int'(bus.locked), 0);
      chk({nm, "_err"}, int'(bus.err), 0);
      chk({nm, "_expected"}, int'(bus.expected), 0);
      chk({nm, "_wrap"}, int'(bus.wrap_pulse), 0);
      chk({nm, "_errc"}, int'(bus.err_count), 0);
      chk({nm, "_wrapc"}, int'(bus.wrap_count), 0);
   endtask

   // Watchdog: the bench must never hang.
   initial begin
      #500000;
      $display("FAIL watchdog: got timeout, required completion");
      $fatal(1, "watchdog expired");
   end

   vec_t tbl[17];

   initial begin
      tbl[0]  = '{1'b1, 4'd5,  1'b0, 1'b0, 1'b0, 4'd6,  1'b0};
      tbl[1]  = '{1'b1, 4'd6,  1'b0, 1'b0, 1'b0, 4'd7,  1'b0};
      tbl[2]  = '{1'b1, 4'd7,  1'b0, 1'b0, 1'b0, 4'd8,  1'b0};
      tbl[3]  = '{1'b1, 4'd8,  1'b0, 1'b1, 1'b0, 4'd9,  1'b0};
      tbl[4]  = '{1'b1, 4'd9,  1'b0, 1'b1, 1'b0, 4'd10, 1'b0};
      tbl[5]  = '{1'b1, 4'd3,  1'b0, 1'b1, 1'b1, 4'd4,  1'b0};
      tbl[6]  = '{1'b1, 4'd4,  1'b0, 1'b1, 1'b0, 4'd5,  1'b0};
      tbl[7]  = '{1'b1, 4'd9,  1'b0, 1'b1, 1'b1, 4'd10, 1'b0};
      tbl[8]  = '{1'b1, 4'd2,  1'b0, 1'b0, 1'b1, 4'd3,  1'b0};
      tbl[9]  = '{1'b1, 4'd12, 1'b0, 1'b0, 1'b0, 4'd13, 1'b0};
      tbl[10] = '{1'b1, 4'd13, 1'b0, 1'b0, 1'b0, 4'd14, 1'b0};
      tbl[11] = '{1'b1, 4'd14, 1'b0, 1'b0, 1'b0, 4'd15, 1'b0};
      tbl[12] = '{1'b1, 4'd15, 1'b0, 1'b1, 1'b0, 4'd0,  1'b0};
      tbl[13] = '{1'b1, 4'd0,  1'b0, 1'b1, 1'b0, 4'd1,  1'b1};
      tbl[14] = '{1'b1, 4'd1,  1'b0, 1'b1, 1'b0, 4'd2,  1'b0};
      tbl[15] = '{1'b0, 4'd7,  1'b0, 1'b1, 1'b0, 4'd2,  1'b0};
      tbl[16] = '{1'b1, 4'd2,  1'b0, 1'b1, 1'b0, 4'd3,  1'b0};

      reset = 1'b0;
      bus.valid = 1'b0; bus.count_in = 4'd0; bus.clear_err = 1'b0;
      model_reset();
      repeat (3) @(posedge clk);
      #1;
      chk_all_zero("reset");
      @(negedge clk);
      reset = 1'b1;

      // Core table: lock, in-lock error, unlock, relock, wrap, idle.
      for (int i = 0; i < 17; i++) begin
         step(tbl[i].v, tbl[i].c, tbl[i].clr);
         chk($sformatf("tbl%0d_locked", i), int'(bus.locked), int'(tbl[i].lk));
         chk($sformatf("tbl%0d_err", i), int'(bus.err), int'(tbl[i].er));
         chk($sformatf("tbl%0d_expected", i), int'(bus.expected), int'(tbl[i].ex));
         chk($sformatf("tbl%0d_wrap", i), int'(bus.wrap_pulse), int'(tbl[i].wr));
      end
      chk("tbl_errc_final", int'(bus.err_count), STATS ? 3 : 0);
      chk("tbl_wrapc_final", int'(bus.wrap_count), STATS ? 1 : 0);

      // Idle for 10 cycles while locked, then resume in sequence.
      for (int i = 0; i < 10; i++) step(1'b0, 4'($urandom_range(0, 15)), 1'b0);
      for (int i = 0; i < 4; i++) step(1'b1, mexp, 1'b0);
      chk("idle_locked_held", int'(bus.locked), 1);

      // 300 isolated errors, each followed by an in-sequence sample.
      for (int i = 0; i < 300; i++) begin
         step(1'b1, mexp + 4'd3, 1'b0);
         step(1'b1, mexp, 1'b0);
      end
      chk("err_saturated", int'(bus.err_count), STATS ? 255 : 0);
      chk("sat_locked", int'(bus.locked), 1);
      step(1'b1, mexp + 4'd5, 1'b1);
      chk("clear_with_err", int'(bus.err_count), STATS ? 1 : 0);
      step(1'b1, mexp, 1'b1);
      chk("clear_no_err", int'(bus.err_count), 0);

      // Wrap counter rolls over modulo 256.
      for (int i = 0; i < 256 * 16 + 3; i++) step(1'b1, mexp, 1'b0);
      chk("wrap_rollover_locked", int'(bus.locked), 1);

      // Asynchronous reset mid-stream while locked.
      #2;
      reset = 1'b0;
      #1;
      chk_all_zero("async_reset");
      model_reset();
      @(negedge clk);
      reset = 1'b1;
      for (int i = 0; i < LOCK - 1; i++) step(1'b1, 4'(i + 14), 1'b0);
      chk("relock_not_yet", int'(bus.locked), 0);
      step(1'b1, mexp, 1'b0);
      chk("relock_done", int'(bus.locked), 1);
      chk("relock_expected", int'(bus.expected), 2);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/count_seq_checker.md
COUNT_SEQ_CHECKER -- requirements
Module: count_seq_checker

Interface
REQ-001 SHALL have parameter LOCK_THRESH, default 4, meaning consecutive in-sequence samples required to lock (range 2..15).
REQ-002 SHALL have parameter UNLOCK_THRESH, default 2, meaning consecutive out-of-sequence samples that drop lock (range 1..15).
REQ-003 SHALL have port clk  input  1  sole clock; all state updates on rising edge.
REQ-004 SHALL have port reset  input  1  asynchronous, active-low reset.
REQ-005 SHALL have port valid  input  1  count_in is sampled this cycle when high.
REQ-006 SHALL have port count_in  input  4  observed value of a free-running modulo-16 up counter.
REQ-007 SHALL have port clear_err  input  1  synchronous clear of err_count.
REQ-008 SHALL have port locked  output  1  high while the state machine is in LOCKED.
REQ-009 SHALL have port err  output  1  one-cycle pulse per out-of-sequence sample seen while LOCKED.
REQ-010 SHALL have port expected  output  4  next value the checker predicts.
REQ-011 SHALL have port wrap_pulse  output  1  one-cycle pulse on an in-sequence 15->0 wrap while LOCKED.
REQ-012 SHALL have port err_count  output  8  saturating count of err pulses.
REQ-013 SHALL have port wrap_count  output  8  modulo-256 count of wrap_pulse events.

Function
REQ-014 SHALL register all outputs; each reflects a sample exactly one clk after the valid sample.
REQ-015 SHALL leave all state unchanged in any cycle with valid low; err and wrap_pulse SHALL be low the following cycle.
REQ-016 SHALL implement states HUNT, SYNC, LOCKED; "match" means valid high and count_in == expected.
REQ-017 HUNT: on valid -> expected <= count_in+1 (mod 16), run <= 1, go to SYNC.
REQ-018 SYNC: match -> expected+1, run+1; when run+1 == LOCK_THRESH go to LOCKED, miss <= 0. Mismatch -> expected <= count_in+1, run <= 1, stay in SYNC.
REQ-019 LOCKED: match -> expected+1, miss <= 0. Mismatch -> err pulse, expected <= count_in+1, miss+1; when miss+1 == UNLOCK_THRESH go to HUNT.
REQ-020 SHALL compute expected with 4-bit wrap: 15+1 = 0.
REQ-021 SHALL assert wrap_pulse only on a LOCKED match with count_in == 0.
REQ-022 SHALL never assert err outside LOCKED; the sample that drops lock SHALL still produce err.
REQ-023 err_count SHALL increment on each err and saturate at 255.
REQ-024 clear_err SHALL zero err_count; when it coincides with an err, err_count SHALL become 1.
REQ-025 wrap_count SHALL increment on each wrap_pulse and roll over from 255 to 0.

Reset
REQ-026 reset low SHALL immediately force state HUNT, run 0, miss 0, expected 0, and locked, err, wrap_pulse, err_count, wrap_count to 0, independent of clk.
REQ-027 Reset release SHALL take effect on clk edges only; the first valid sample after release SHALL be handled as a HUNT sample.
REQ-028 Assertion of reset while LOCKED SHALL discard lock; no err SHALL be generated for the interrupted sequence.

Configuration
REQ-029 Macro SEQ_CHECK_STATS_EN defined: err_count, wrap_count and clear_err behave per REQ-023..025.
REQ-030 Macro SEQ_CHECK_STATS_EN undefined: no statistics registers; err_count and wrap_count SHALL be constant 0 and clear_err ignored; all other behaviour identical.

Verification
REQ-031 Reset, then valid every cycle with count_in 5,6,7,8 -> locked rises 1 clk after the sample 8; expected = 9; err never high.
REQ-032 Locked, feed 13,14,15,0,1 -> wrap_pulse high exactly once, 1 clk after the 0; wrap_count = 1; err low.
REQ-033 Locked at expected 10, feed 3 then 4 -> err pulses once, locked stays high, expected = 5; feed 9 then 2 (UNLOCK_THRESH 2) -> two err pulses, locked falls after the second.
REQ-034 Locked, 300 mismatching samples with lock re-established between them -> err_count saturates at 255; clear_err coincident with an err -> err_count = 1.
REQ-035 Locked, valid low for 10 cycles, then resume in sequence -> no err, locked held; reset pulse mid-stream -> all outputs 0 asynchronously, re-lock needs LOCK_THRESH samples.
REQ-036 Build with SEQ_CHECK_STATS_EN undefined and rerun REQ-032/034 stimulus -> err and wrap_pulse unchanged; err_count and wrap_count constant 0.
